// File: rtl/disk_head_ctrl.sv
// Floppy head controller: soft-switch decode, spindle spin-down timer, half-track stepper.
// Switch writes land on the next clk edge; head moves are evaluated on ce_1m ticks and followed by a settle hold-off.
module disk_head_ctrl #(
  parameter int MOTOR_DELAY = 1000000,
  parameter int STEP_SETTLE = 1000,
  parameter int HT_MAX      = 68
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_1m,
  input  logic       io_sel,
  input  logic [3:0] a,
  output logic [3:0] phs,
  output logic       motor,
  output logic       drive2,
  output logic       q6,
  output logic       q7,
  output logic [6:0] half_track,
  output logic [5:0] track,
  output logic       step_pulse
);

  localparam int MW = (MOTOR_DELAY < 2) ? 1 : $clog2(MOTOR_DELAY + 1);
  localparam int SW = (STEP_SETTLE < 2) ? 1 : $clog2(STEP_SETTLE + 1);
  localparam logic [MW-1:0] MLOAD  = MW'(MOTOR_DELAY);
  localparam logic [SW-1:0] SLOAD  = SW'(STEP_SETTLE);
  localparam logic [6:0]    HT_LIM = 7'(HT_MAX);

  typedef enum logic {IDLE, SETTLE} step_state_t;

  step_state_t     state_q, state_d;
  logic [6:0]      ht_q, ht_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            pulse_q, pulse_d;
  logic            tmr_act;
  logic [MW-1:0]   tmr_cnt;
  logic [1:0]      p, pu, pd;
  logic            mv_up, mv_dn;

  // Phase magnets and the drive/Q latches
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phs    <= 4'b0000;
      drive2 <= 1'b0;
      q6     <= 1'b0;
      q7     <= 1'b0;
    end else if (io_sel) begin
      case (a)
        4'hA:    drive2 <= 1'b0;
        4'hB:    drive2 <= 1'b1;
        4'hC:    q6 <= 1'b0;
        4'hD:    q6 <= 1'b1;
        4'hE:    q7 <= 1'b0;
        4'hF:    q7 <= 1'b1;
        4'h8,
        4'h9:    ;
        default: phs[a[2:1]] <= a[0];
      endcase
    end
  end

  // Later assignments win: a=9 overrides an expiry on the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      motor   <= 1'b0;
      tmr_act <= 1'b0;
      tmr_cnt <= '0;
    end else begin
      if (tmr_act && ce_1m) begin
        if (tmr_cnt <= MW'(1)) begin
          motor   <= 1'b0;
          tmr_act <= 1'b0;
          tmr_cnt <= '0;
        end else begin
          tmr_cnt <= tmr_cnt - MW'(1);
        end
      end
      if (io_sel && a == 4'h9) begin
        motor   <= 1'b1;
        tmr_act <= 1'b0;
      end else if (io_sel && a == 4'h8 && motor && !tmr_act) begin
        tmr_act <= 1'b1;
        tmr_cnt <= MLOAD;
      end
    end
  end

  assign p     = ht_q[1:0];
  assign pu    = p + 2'd1;
  assign pd    = p + 2'd3;
  assign mv_up = phs[pu] && !phs[pd] && (ht_q < HT_LIM);
  assign mv_dn = phs[pd] && !phs[pu] && (ht_q != 7'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ht_q     <= 7'd0;
      settle_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ht_q     <= ht_d;
      settle_q <= settle_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ht_d     = ht_q;
    settle_d = settle_q;
    pulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ce_1m && motor && (mv_up || mv_dn)) begin
          ht_d     = mv_up ? ht_q + 7'd1 : ht_q - 7'd1;
          pulse_d  = 1'b1;
          settle_d = SLOAD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        // Counts down regardless of motor so a stopped drive still settles
        if (ce_1m) begin
          if (settle_q <= SW'(1)) begin
            settle_d = '0;
            state_d  = IDLE;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign half_track = ht_q;
  assign track      = ht_q[6:1];
  assign step_pulse = pulse_q;

endmodule
